// File: rtl/cellrv32_bus_switch_if.sv
`default_nettype none
// ============================================================================
// Module      : cellrv32_bus_switch_if
// Description : Signal bundle of the two-port to one-port bus switch:
//               host port A, host port B and the processor-internal bus.
//               'slave' is the switch-side view, 'master' the environment
//               view (hosts plus bus devices).
// Revision    : 1.0 - initial release
// ============================================================================
interface cellrv32_bus_switch_if;
  // port A (CPU data port)
  logic [31:0] a_addr_i;
  logic [31:0] a_wdata_i;
  logic [3:0]  a_ben_i;
  logic        a_re_i;
  logic        a_we_i;
  logic [31:0] a_rdata_o;
  logic        a_ack_o;
  logic        a_err_o;
  // port B (instruction fetch port)
  logic [31:0] b_addr_i;
  logic [31:0] b_wdata_i;
  logic [3:0]  b_ben_i;
  logic        b_re_i;
  logic        b_we_i;
  logic [31:0] b_rdata_o;
  logic        b_ack_o;
  logic        b_err_o;
  // processor-internal bus
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_ben_o;
  logic        bus_re_o;
  logic        bus_we_o;
  logic        bus_src_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_i;

  modport slave (
    input  a_addr_i, a_wdata_i, a_ben_i, a_re_i, a_we_i,
    output a_rdata_o, a_ack_o, a_err_o,
    input  b_addr_i, b_wdata_i, b_ben_i, b_re_i, b_we_i,
    output b_rdata_o, b_ack_o, b_err_o,
    output bus_addr_o, bus_wdata_o, bus_ben_o, bus_re_o, bus_we_o, bus_src_o,
    input  bus_rdata_i, bus_ack_i, bus_err_i
  );

  modport master (
    output a_addr_i, a_wdata_i, a_ben_i, a_re_i, a_we_i,
    input  a_rdata_o, a_ack_o, a_err_o,
    output b_addr_i, b_wdata_i, b_ben_i, b_re_i, b_we_i,
    input  b_rdata_o, b_ack_o, b_err_o,
    input  bus_addr_o, bus_wdata_o, bus_ben_o, bus_re_o, bus_we_o, bus_src_o,
    output bus_rdata_i, bus_ack_i, bus_err_i
  );
endinterface
`default_nettype wire

// File: rtl/cellrv32_bus_switch.sv
`default_nettype none
// ============================================================================
// Module      : cellrv32_bus_switch
// Description : Merges the CPU data port (A) and the instruction-fetch port
//               (B) onto the single processor-internal bus. Single-cycle
//               request strobes are buffered, accesses are serialised, and
//               ack/err (including bus keeper terminations) are routed back
//               to the port that owns the in-flight access. A is preferred,
//               but a B request that lost once is served next.
// Revision    : 1.0 - initial release
// ============================================================================
module cellrv32_bus_switch #(
  parameter bit PORT_A_READ_ONLY = 1'b0,
  parameter bit PORT_B_READ_ONLY = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  cellrv32_bus_switch_if.slave sw
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_A = 2'd1,
    S_BUSY_B = 2'd2
  } state_t;

  state_t r_state;
  logic   r_sel;        // 0 = A owns the bus, 1 = B owns the bus
  logic   r_b_starved;  // B lost an arbitration round and must win the next
  logic   r_bus_re;
  logic   r_bus_we;

  logic   r_a_rd_pend, r_a_wr_pend;
  logic   r_b_rd_pend, r_b_wr_pend;

  logic   w_a_we_eff, w_b_we_eff;
  logic   w_a_free,   w_b_free;
  logic   w_a_new_rd, w_a_new_wr;
  logic   w_b_new_rd, w_b_new_wr;
  logic   w_a_req_rd, w_a_req_wr, w_a_req;
  logic   w_b_req_rd, w_b_req_wr, w_b_req;
  logic   w_grant_a,  w_grant_b;
  logic   w_term;

  // Request capture and arbitration decision; a strobe only counts when
  // the port has nothing pending and nothing in flight, and write beats read.
  always_comb begin
    w_a_we_eff = sw.a_we_i & ~PORT_A_READ_ONLY;
    w_b_we_eff = sw.b_we_i & ~PORT_B_READ_ONLY;

    w_a_free   = ~(r_a_rd_pend | r_a_wr_pend | (r_state == S_BUSY_A));
    w_b_free   = ~(r_b_rd_pend | r_b_wr_pend | (r_state == S_BUSY_B));

    w_a_new_wr = w_a_free & w_a_we_eff;
    w_a_new_rd = w_a_free & sw.a_re_i & ~w_a_we_eff;
    w_b_new_wr = w_b_free & w_b_we_eff;
    w_b_new_rd = w_b_free & sw.b_re_i & ~w_b_we_eff;

    w_a_req_wr = r_a_wr_pend | w_a_new_wr;
    w_a_req_rd = r_a_rd_pend | w_a_new_rd;
    w_b_req_wr = r_b_wr_pend | w_b_new_wr;
    w_b_req_rd = r_b_rd_pend | w_b_new_rd;
    w_a_req    = w_a_req_wr | w_a_req_rd;
    w_b_req    = w_b_req_wr | w_b_req_rd;

    w_grant_a  = (r_state == S_IDLE) & w_a_req & ~(w_b_req & r_b_starved);
    w_grant_b  = (r_state == S_IDLE) & w_b_req & ~w_grant_a;

    w_term     = sw.bus_ack_i | sw.bus_err_i;
  end

  // Arbiter FSM with registered one-cycle bus strobes and source select.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_b_starved <= 1'b0;
      r_bus_re    <= 1'b0;
      r_bus_we    <= 1'b0;
    end else begin
      r_bus_re <= 1'b0;
      r_bus_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_a) begin
            r_state  <= S_BUSY_A;
            r_sel    <= 1'b0;
            r_bus_re <= w_a_req_rd;
            r_bus_we <= w_a_req_wr;
            if (w_b_req) begin
              r_b_starved <= 1'b1;
            end
          end else if (w_grant_b) begin
            r_state     <= S_BUSY_B;
            r_sel       <= 1'b1;
            r_bus_re    <= w_b_req_rd;
            r_bus_we    <= w_b_req_wr;
            r_b_starved <= 1'b0;
          end
        end
        S_BUSY_A, S_BUSY_B: begin
          if (w_term) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Port A request buffer: captured strobe held until A is granted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_a_rd_pend <= 1'b0;
      r_a_wr_pend <= 1'b0;
    end else if (w_grant_a) begin
      r_a_rd_pend <= 1'b0;
      r_a_wr_pend <= 1'b0;
    end else begin
      if (w_a_new_rd) r_a_rd_pend <= 1'b1;
      if (w_a_new_wr) r_a_wr_pend <= 1'b1;
    end
  end

  // Port B request buffer: captured strobe held until B is granted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_b_rd_pend <= 1'b0;
      r_b_wr_pend <= 1'b0;
    end else if (w_grant_b) begin
      r_b_rd_pend <= 1'b0;
      r_b_wr_pend <= 1'b0;
    end else begin
      if (w_b_new_rd) r_b_rd_pend <= 1'b1;
      if (w_b_new_wr) r_b_wr_pend <= 1'b1;
    end
  end

  // Bus side: address/data follow the owner, strobes come from registers.
  always_comb begin
    sw.bus_addr_o  = r_sel ? sw.b_addr_i  : sw.a_addr_i;
    sw.bus_wdata_o = r_sel ? sw.b_wdata_i : sw.a_wdata_i;
    sw.bus_ben_o   = r_sel ? sw.b_ben_i   : sw.a_ben_i;
    sw.bus_src_o   = r_sel;
    sw.bus_re_o    = r_bus_re;
    sw.bus_we_o    = r_bus_we;
  end

  // Host side: terminations pass through combinationally to the owner only;
  // terminations while idle are dropped.
  always_comb begin
    sw.a_ack_o   = (r_state == S_BUSY_A) & sw.bus_ack_i;
    sw.a_err_o   = (r_state == S_BUSY_A) & sw.bus_err_i;
    sw.b_ack_o   = (r_state == S_BUSY_B) & sw.bus_ack_i;
    sw.b_err_o   = (r_state == S_BUSY_B) & sw.bus_err_i;
    sw.a_rdata_o = sw.a_ack_o ? sw.bus_rdata_i : 32'h0000_0000;
    sw.b_rdata_o = sw.b_ack_o ? sw.bus_rdata_i : 32'h0000_0000;
  end

endmodule
`default_nettype wire

// File: tb/tb_cellrv32_bus_switch.sv
`default_nettype none
// ============================================================================
// Module      : tb_cellrv32_bus_switch
// Description : Directed self-checking bench for cellrv32_bus_switch.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cellrv32_bus_switch;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  cellrv32_bus_switch_if sw_if ();

  cellrv32_bus_switch #(
    .PORT_A_READ_ONLY (1'b0),
    .PORT_B_READ_ONLY (1'b1)
  ) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .sw     (sw_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Strobes and bus responses default to inactive every cycle.
  task automatic idle_inputs();
    sw_if.a_re_i      = 1'b0;
    sw_if.a_we_i      = 1'b0;
    sw_if.b_re_i      = 1'b0;
    sw_if.b_we_i      = 1'b0;
    sw_if.bus_ack_i   = 1'b0;
    sw_if.bus_err_i   = 1'b0;
    sw_if.bus_rdata_i = 32'h0;
  endtask

  initial begin
    sw_if.a_addr_i  = 32'h0;
    sw_if.a_wdata_i = 32'h0;
    sw_if.a_ben_i   = 4'hF;
    sw_if.b_addr_i  = 32'h0;
    sw_if.b_wdata_i = 32'h0;
    sw_if.b_ben_i   = 4'hF;
    idle_inputs();

    // ---------------- reset state
    tick(); tick();
    #1;
    chk("rst_bus_re",  {31'b0, sw_if.bus_re_o},  32'd0);
    chk("rst_bus_we",  {31'b0, sw_if.bus_we_o},  32'd0);
    chk("rst_bus_src", {31'b0, sw_if.bus_src_o}, 32'd0);
    chk("rst_a_ack",   {31'b0, sw_if.a_ack_o},   32'd0);
    chk("rst_a_rdata", sw_if.a_rdata_o,          32'd0);
    rstn_i = 1'b1;
    tick();

    // ---------------- A read alone
    tick(); idle_inputs(); sw_if.a_addr_i = 32'hFFFF_FE00; sw_if.a_re_i = 1'b1; #1;   // t
    tick(); idle_inputs(); #1;                                                        // t+1
    chk("t1_bus_re",   {31'b0, sw_if.bus_re_o},  32'd1);
    chk("t1_bus_addr", sw_if.bus_addr_o,         32'hFFFF_FE00);
    chk("t1_bus_src",  {31'b0, sw_if.bus_src_o}, 32'd0);
    tick(); idle_inputs(); sw_if.bus_rdata_i = 32'h0000_1234; #1;                     // t+2
    chk("t1_re_one_cycle", {31'b0, sw_if.bus_re_o}, 32'd0);
    chk("t1_rdata_gated",  sw_if.a_rdata_o,         32'd0);
    tick(); idle_inputs(); sw_if.bus_ack_i = 1'b1; sw_if.bus_rdata_i = 32'hDEAD_BEEF; #1; // t+3
    chk("t1_a_ack",   {31'b0, sw_if.a_ack_o}, 32'd1);
    chk("t1_a_rdata", sw_if.a_rdata_o,        32'hDEAD_BEEF);
    chk("t1_b_ack",   {31'b0, sw_if.b_ack_o}, 32'd0);
    chk("t1_b_rdata", sw_if.b_rdata_o,        32'd0);
    tick(); idle_inputs(); #1;
    chk("t1_a_ack_drop", {31'b0, sw_if.a_ack_o}, 32'd0);

    // ---------------- simultaneous A write and B read
    tick(); idle_inputs();                                                           // t
    sw_if.a_we_i = 1'b1; sw_if.a_wdata_i = 32'h1122_3344; sw_if.a_addr_i = 32'h0000_0040;
    sw_if.b_re_i = 1'b1; sw_if.b_addr_i = 32'h0000_0100; #1;
    tick(); idle_inputs(); #1;                                                        // t+1
    chk("t2_bus_we",    {31'b0, sw_if.bus_we_o},  32'd1);
    chk("t2_bus_re",    {31'b0, sw_if.bus_re_o},  32'd0);
    chk("t2_src_a",     {31'b0, sw_if.bus_src_o}, 32'd0);
    chk("t2_bus_wdata", sw_if.bus_wdata_o,        32'h1122_3344);
    tick(); idle_inputs(); sw_if.bus_ack_i = 1'b1; #1;                                // t+2
    chk("t2_a_ack", {31'b0, sw_if.a_ack_o}, 32'd1);
    chk("t2_b_ack", {31'b0, sw_if.b_ack_o}, 32'd0);
    tick(); idle_inputs(); #1;                                                        // t+3
    chk("t2_idle_gap", {31'b0, sw_if.bus_re_o}, 32'd0);
    tick(); idle_inputs(); #1;                                                        // t+4
    chk("t2_b_re",   {31'b0, sw_if.bus_re_o},  32'd1);
    chk("t2_src_b",  {31'b0, sw_if.bus_src_o}, 32'd1);
    chk("t2_b_addr", sw_if.bus_addr_o,         32'h0000_0100);
    tick(); idle_inputs(); sw_if.bus_ack_i = 1'b1; sw_if.bus_rdata_i = 32'hCAFE_F00D; #1; // t+5
    chk("t2_b_ack2",  {31'b0, sw_if.b_ack_o}, 32'd1);
    chk("t2_b_rdata", sw_if.b_rdata_o,        32'hCAFE_F00D);
    chk("t2_a_quiet", {31'b0, sw_if.a_ack_o}, 32'd0);
    tick(); idle_inputs(); #1;

    // ---------------- starvation: A strobes every cycle, B pending
    tick(); idle_inputs(); sw_if.a_re_i = 1'b1; sw_if.b_re_i = 1'b1; #1;             // t
    tick(); idle_inputs(); sw_if.a_re_i = 1'b1; #1;                                   // t+1
    chk("t3_first_src", {31'b0, sw_if.bus_src_o}, 32'd0);
    chk("t3_first_re",  {31'b0, sw_if.bus_re_o},  32'd1);
    tick(); idle_inputs(); sw_if.a_re_i = 1'b1; sw_if.bus_ack_i = 1'b1; #1;           // t+2
    chk("t3_a_ack", {31'b0, sw_if.a_ack_o}, 32'd1);
    tick(); idle_inputs(); sw_if.a_re_i = 1'b1; #1;                                   // t+3 idle
    tick(); idle_inputs(); sw_if.a_re_i = 1'b1; #1;                                   // t+4
    chk("t3_b_wins_re",  {31'b0, sw_if.bus_re_o},  32'd1);
    chk("t3_b_wins_src", {31'b0, sw_if.bus_src_o}, 32'd1);
    tick(); idle_inputs(); sw_if.a_re_i = 1'b1; sw_if.bus_ack_i = 1'b1; #1;           // t+5
    chk("t3_b_ack", {31'b0, sw_if.b_ack_o}, 32'd1);
    chk("t3_a_nak", {31'b0, sw_if.a_ack_o}, 32'd0);
    tick(); idle_inputs(); sw_if.a_re_i = 1'b1; #1;                                   // t+6 idle
    tick(); idle_inputs(); #1;                                                        // t+7
    chk("t3_then_a_re",  {31'b0, sw_if.bus_re_o},  32'd1);
    chk("t3_then_a_src", {31'b0, sw_if.bus_src_o}, 32'd0);
    tick(); idle_inputs(); sw_if.bus_ack_i = 1'b1; #1;                                // t+8
    chk("t3_a_ack2", {31'b0, sw_if.a_ack_o}, 32'd1);
    tick(); idle_inputs(); #1;
    tick(); idle_inputs(); #1;
    chk("t3_no_extra", {31'b0, sw_if.bus_re_o}, 32'd0);

    // ---------------- B read terminated by error, then A served
    tick(); idle_inputs(); sw_if.b_re_i = 1'b1; #1;                                   // t
    tick(); idle_inputs(); #1;                                                        // t+1
    chk("t4_b_re", {31'b0, sw_if.bus_src_o}, 32'd1);
    tick(); idle_inputs(); sw_if.bus_err_i = 1'b1; #1;                                // t+2
    chk("t4_b_err",   {31'b0, sw_if.b_err_o}, 32'd1);
    chk("t4_b_noack", {31'b0, sw_if.b_ack_o}, 32'd0);
    chk("t4_a_noerr", {31'b0, sw_if.a_err_o}, 32'd0);
    tick(); idle_inputs(); sw_if.a_re_i = 1'b1; #1;                                   // t+3
    chk("t4_b_err_drop", {31'b0, sw_if.b_err_o}, 32'd0);
    tick(); idle_inputs(); #1;                                                        // t+4
    chk("t4_a_re",  {31'b0, sw_if.bus_re_o},  32'd1);
    chk("t4_a_src", {31'b0, sw_if.bus_src_o}, 32'd0);
    tick(); idle_inputs(); sw_if.bus_ack_i = 1'b1; #1;                                // t+5
    chk("t4_a_ack", {31'b0, sw_if.a_ack_o}, 32'd1);
    tick(); idle_inputs(); sw_if.bus_ack_i = 1'b1; sw_if.bus_err_i = 1'b1; #1;        // idle ack
    chk("t4_idle_a_ack", {31'b0, sw_if.a_ack_o}, 32'd0);
    chk("t4_idle_b_err", {31'b0, sw_if.b_err_o}, 32'd0);

    // ---------------- read-only B write, A re+we, duplicate A strobe
    tick(); idle_inputs(); sw_if.b_we_i = 1'b1; #1;                                   // t
    tick(); idle_inputs(); #1;
    chk("t5_ro_we", {31'b0, sw_if.bus_we_o}, 32'd0);
    chk("t5_ro_re", {31'b0, sw_if.bus_re_o}, 32'd0);
    tick(); idle_inputs(); sw_if.bus_ack_i = 1'b1; #1;
    chk("t5_ro_ack", {31'b0, sw_if.b_ack_o}, 32'd0);
    tick(); idle_inputs(); sw_if.a_re_i = 1'b1; sw_if.a_we_i = 1'b1; #1;              // t
    tick(); idle_inputs(); #1;                                                        // t+1
    chk("t5_wwins_we", {31'b0, sw_if.bus_we_o}, 32'd1);
    chk("t5_wwins_re", {31'b0, sw_if.bus_re_o}, 32'd0);
    tick(); idle_inputs(); sw_if.a_re_i = 1'b1; #1;                                   // t+2 dup
    tick(); idle_inputs(); sw_if.bus_ack_i = 1'b1; #1;                                // t+3
    chk("t5_a_ack", {31'b0, sw_if.a_ack_o}, 32'd1);
    tick(); idle_inputs(); #1;
    tick(); idle_inputs(); #1;
    chk("t5_dup_re", {31'b0, sw_if.bus_re_o}, 32'd0);
    chk("t5_dup_we", {31'b0, sw_if.bus_we_o}, 32'd0);

    // ---------------- reset mid-access with B pending
    tick(); idle_inputs(); sw_if.a_re_i = 1'b1; #1;                                   // t
    tick(); idle_inputs(); sw_if.b_re_i = 1'b1; #1;                                   // t+1
    chk("t6_a_re", {31'b0, sw_if.bus_re_o}, 32'd1);
    tick(); idle_inputs(); rstn_i = 1'b0; #1;                                         // t+2
    sw_if.bus_ack_i = 1'b1; #1;
    chk("t6_rst_ack", {31'b0, sw_if.a_ack_o}, 32'd0);
    tick(); idle_inputs(); #1;                                                        // t+3
    chk("t6_rst_re", {31'b0, sw_if.bus_re_o}, 32'd0);
    tick(); idle_inputs(); rstn_i = 1'b1; sw_if.bus_ack_i = 1'b1; #1;                 // t+4
    chk("t6_late_ack", {31'b0, sw_if.a_ack_o}, 32'd0);
    tick(); idle_inputs(); #1;
    chk("t6_no_b_re", {31'b0, sw_if.bus_re_o}, 32'd0);
    tick(); idle_inputs(); #1;
    chk("t6_no_b_re2", {31'b0, sw_if.bus_re_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
